inc_share_arbiter: RTL and testbench

//   Shares one INC datapath unit (d = a + 1) between NUM_REQ requesters.

---
 rtl/inc_share_arbiter.sv | 145 ++++++++++++++
 tb/tb_inc_share_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inc_share_arbiter.sv
// ============================================================================
//  Module   : inc_share_arbiter (with helper module inc)
//  Purpose  : Lets NUM_REQ requesters share one incrementer (d = a + 1).
//             A round-robin arbiter picks one request per cycle. The result is
//             placed in a one-entry register, tagged with the requester index,
//             and leaves through a valid/ready response port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// Incrementer that the requesters share. Arithmetic wraps modulo 2^DATAWIDTH.
module inc #(
  parameter int DATAWIDTH = 32
) (
  input  logic [DATAWIDTH-1:0] i_a,
  output logic [DATAWIDTH-1:0] o_d
);
  assign o_d = i_a + DATAWIDTH'(1);
endmodule

module inc_share_arbiter #(
  parameter int DATAWIDTH = 32,
  parameter int NUM_REQ   = 4
) (
  input  logic                         clk,
  input  logic                         rst,        // asynchronous, active-low
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATAWIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         rsp_valid,
  output logic [DATAWIDTH-1:0]         rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  input  logic                         rsp_ready
);

  localparam int ID_W = $clog2(NUM_REQ);

  // The state records whether the result register is occupied
  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t                 r_state;
  logic [ID_W-1:0]        r_last;       // most recently granted requester
  logic [DATAWIDTH-1:0]   r_rsp_data;
  logic [ID_W-1:0]        r_rsp_id;

  logic                   w_can_accept;
  logic                   w_grant_any;
  logic [ID_W-1:0]        w_grant_id;
  logic [ID_W-1:0]        w_scan_id;
  int                     w_scan_idx;
  logic [NUM_REQ-1:0]     w_grant_vec;
  logic [DATAWIDTH-1:0]   w_sel_operand;
  logic [DATAWIDTH-1:0]   w_inc_result;

  // A new operand can be taken when the register is empty or is being drained
  assign w_can_accept = (r_state == S_EMPTY) | rsp_ready;

  // Round-robin search: scan upward from the requester after the last grant
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_id  = '0;
    w_scan_idx  = 0;
    w_scan_id   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_scan_idx = (int'(r_last) + k) % NUM_REQ;
      w_scan_id  = ID_W'(w_scan_idx);
      if (!w_grant_any && req_valid[w_scan_id]) begin
        w_grant_any = 1'b1;
        w_grant_id  = w_scan_id;
      end
    end
  end

  // One-hot grant, driven only while a new operand can be accepted
  always_comb begin
    w_grant_vec = '0;
    if (w_can_accept && w_grant_any) begin
      w_grant_vec[w_grant_id] = 1'b1;
    end
  end

  // The grant is forced low while reset is held, even before any clock edge
  assign req_ready = w_grant_vec & {NUM_REQ{rst}};

  // Operand mux in front of the shared incrementer
  always_comb begin
    w_sel_operand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant_id == ID_W'(k)) begin
        w_sel_operand = req_data[k*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  inc #(
    .DATAWIDTH (DATAWIDTH)
  ) u_inc (
    .i_a (w_sel_operand),
    .o_d (w_inc_result)
  );

  // Result register occupancy FSM. It captures the tagged result on each grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_EMPTY;
      r_last     <= ID_W'(NUM_REQ - 1);
      r_rsp_data <= '0;
      r_rsp_id   <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_grant_any) begin
            r_rsp_data <= w_inc_result;
            r_rsp_id   <= w_grant_id;
            r_last     <= w_grant_id;
            r_state    <= S_FULL;
          end
        end
        S_FULL: begin
          if (rsp_ready) begin
            if (w_grant_any) begin
              // Back-to-back: drain the old result and capture the new one
              r_rsp_data <= w_inc_result;
              r_rsp_id   <= w_grant_id;
              r_last     <= w_grant_id;
            end else begin
              r_state <= S_EMPTY;
            end
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  assign rsp_valid = (r_state == S_FULL);
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;

endmodule

`default_nettype wire

// File: tb/tb_inc_share_arbiter.sv
// ============================================================================
//  Module   : tb_inc_share_arbiter
//  Purpose  : Self-checking bench for inc_share_arbiter. A reference model
//             predicts grants and queues the expected results. A separate
//             monitor pops that queue on every response handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inc_share_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int IW = $clog2(NR);

  logic               clk;
  logic               rst;
  logic [NR-1:0]      req_valid;
  logic [NR*DW-1:0]   req_data;
  logic [NR-1:0]      req_ready;
  logic               rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic [IW-1:0]      rsp_id;
  logic               rsp_ready;

  inc_share_arbiter #(
    .DATAWIDTH (DW),
    .NUM_REQ   (NR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int          id;
    logic [31:0] d;
  } exp_t;

  exp_t        sb_q[$];
  int          m_last;
  bit          m_full;
  int          waitc[NR];

  // Each cycle, predict the grant from the round-robin rule and queue the result
  initial begin
    m_last = NR - 1;
    m_full = 0;
    for (int i = 0; i < NR; i++) waitc[i] = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("reset_req_ready", 64'(req_ready), 64'(0));
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        m_last = NR - 1;
        m_full = 0;
        sb_q.delete();
        for (int i = 0; i < NR; i++) waitc[i] = 0;
      end else begin
        int          g;
        bit          can;
        logic [31:0] opnd;
        g   = -1;
        can = !m_full || rsp_ready;
        check("model_rsp_valid", 64'(rsp_valid), 64'(m_full));
        if (can) begin
          for (int k = 1; k <= NR; k++) begin
            int idx;
            idx = (m_last + k) % NR;
            if (g < 0 && req_valid[idx]) g = idx;
          end
        end
        check("model_req_ready", 64'(req_ready), (g >= 0) ? (64'(1) << g) : 64'(0));
        for (int i = 0; i < NR; i++) begin
          if (req_valid[i] && g >= 0 && g != i) begin
            waitc[i]++;
            check("starvation_bound", 64'(waitc[i] <= NR - 1), 64'(1));
          end else if (!req_valid[i] || g == i) begin
            waitc[i] = 0;
          end
        end
        if (g >= 0) begin
          exp_t e;
          opnd = req_data[g*DW +: DW];
          e.id = g;
          e.d  = opnd + 32'd1;
          sb_q.push_back(e);
          m_last = g;
          m_full = 1;
        end else if (m_full && rsp_ready) begin
          m_full = 0;
        end
      end
    end
  end

  // Monitor: on every response handshake, compare the DUT against the oldest expected result
  initial begin
    forever begin
      @(negedge clk);
      if (rst && rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_rsp", 64'(1), 64'(0));
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_rsp_id", 64'(rsp_id), 64'(e.id));
          check("sb_rsp_data", 64'(rsp_data), 64'(e.d));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  logic [DW-1:0] hold_d;
  logic [IW-1:0] hold_id;
  logic [NR-1:0] acc;

  initial begin
    rst       = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    #1;
    check("reset_rsp_valid_async", 64'(rsp_valid), 64'(0));
    check("reset_rsp_data", 64'(rsp_data), 64'(0));
    check("reset_rsp_id", 64'(rsp_id), 64'(0));
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // T1: single requester 0, operand 5
    drive_cycle();
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    req_data[0*DW +: DW] = 32'd5;
    @(negedge clk);
    check("t1_req_ready", 64'(req_ready), 64'(4'b0001));
    drive_cycle();
    req_valid = '0;
    @(negedge clk);
    check("t1_rsp_valid", 64'(rsp_valid), 64'(1));
    check("t1_rsp_data", 64'(rsp_data), 64'(6));
    check("t1_rsp_id", 64'(rsp_id), 64'(0));

    // T2: all-ones operand wraps to zero
    drive_cycle();
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 32'hFFFF_FFFF;
    drive_cycle();
    req_valid = '0;
    @(negedge clk);
    check("t2_rsp_data", 64'(rsp_data), 64'(0));
    check("t2_rsp_id", 64'(rsp_id), 64'(2));

    // T3: all four requesting from a fresh pointer -> ids 0,1,2,3,0,1
    do_reset();
    drive_cycle();
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 32'(100 * i);
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (n > 0) begin
        check("t3_rsp_id", 64'(rsp_id), 64'((n - 1) % NR));
        check("t3_rsp_data", 64'(rsp_data), 64'(100 * ((n - 1) % NR) + 1));
      end
    end
    @(negedge clk);
    check("t3_rsp_id", 64'(rsp_id), 64'(1));

    // T4: stall with rsp_ready low for 3 cycles
    drive_cycle();
    rsp_ready = 1'b0;
    @(negedge clk);
    hold_d  = rsp_data;
    hold_id = rsp_id;
    for (int n = 0; n < 3; n++) begin
      if (n > 0) @(negedge clk);
      check("t4_hold_data", 64'(rsp_data), 64'(hold_d));
      check("t4_hold_id", 64'(rsp_id), 64'(hold_id));
      check("t4_req_ready", 64'(req_ready), 64'(0));
      check("t4_rsp_valid", 64'(rsp_valid), 64'(1));
    end
    drive_cycle();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t4_next_grant", 64'(req_ready), 64'(1) << ((hold_id + 1) % NR));

    // T5: asynchronous reset while FULL and all requesting
    drive_cycle();
    #1 rst = 1'b0;
    #1;
    check("t5_rsp_valid_async", 64'(rsp_valid), 64'(0));
    check("t5_req_ready", 64'(req_ready), 64'(0));
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("t5_first_grant", 64'(req_ready), 64'(4'b0001));

    // T6: randomized traffic, checked by the model and monitor
    acc = '0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      drive_cycle();
      for (int i = 0; i < NR; i++) begin
        if (acc[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 1) == 1);
          req_data[i*DW +: DW] = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
        end else if ($urandom_range(0, 9) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("final_sb_empty", 64'(sb_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
